// File: rtl/mem_bus_fabric.sv
// ---------------------------------------------------------------------------
// mem_bus_fabric
//
// Data-memory fabric between the processor memory stage and its data-side
// targets. It has four targets: display RAM, keyboard FIFO (data and status),
// data SRAM, and an error response for unmapped addresses. The display RAM
// has a second, independent read port that feeds the VGA tile engine with
// halfwords.
//
// Address map (byte address Ma, bits [1:0] ignored):
//   Ma[31:20] = 12'hB00     display RAM, word Ma[DISP_AW+1:2]
//   Ma        = A000_0000   KEYDATA  (read pops the FIFO)
//   Ma        = A000_0004   KEYSTAT  (read clears overflow)
//   Ma[31:16] = 16'h1000    data SRAM, word Ma[SRAM_AW+1:2]
//   anything else           unmapped: bus_err pulse, read data 0
//
// Ports:
//   clk, reset          single clock; synchronous active-high reset
//   dmen, dmwr          access request and write qualifier
//   Ma, MD2             byte address and write data
//   MDout               read data, valid the cycle after a read
//   md_ready, bus_err   one-cycle completion and unmapped-access pulses
//   char_addr           halfword address for the tile engine
//   char_data_out       halfword, valid the cycle after char_addr
//   key_valid, key_data keyboard receiver push strobe and scan code
// ---------------------------------------------------------------------------
module mem_bus_fabric #(
  parameter int DISP_AW   = 13,
  parameter int SRAM_AW   = 12,
  parameter int KEY_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dmen,
  input  logic               dmwr,
  input  logic [31:0]        Ma,
  input  logic [31:0]        MD2,
  output logic [31:0]        MDout,
  output logic               md_ready,
  output logic               bus_err,
  input  logic [DISP_AW:0]   char_addr,
  output logic [15:0]        char_data_out,
  input  logic               key_valid,
  input  logic [7:0]         key_data
);

  localparam int KPW = $clog2(KEY_DEPTH);

  // Which registered source drives MDout; it changes only on reads, so
  // MDout holds across idle cycles and writes.
  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_DISP,
    SRC_SRAM,
    SRC_KEY
  } src_e;

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic               is_disp;
  logic               is_sram;
  logic               is_keydata;
  logic               is_keystat;
  logic               is_mapped;
  logic               rd_en;
  logic               wr_en;
  logic [DISP_AW-1:0] disp_idx;
  logic [SRAM_AW-1:0] sram_idx;
  logic [DISP_AW-1:0] char_idx;
  logic               unused_ma;

  assign is_disp    = (Ma[31:20] == 12'hB00);
  assign is_sram    = (Ma[31:16] == 16'h1000);
  assign is_keydata = (Ma[31:2] == 30'h2800_0000);
  assign is_keystat = (Ma[31:2] == 30'h2800_0001);
  assign is_mapped  = is_disp | is_sram | is_keydata | is_keystat;
  assign rd_en      = dmen & ~dmwr;
  assign wr_en      = dmen & dmwr;
  assign disp_idx   = Ma[DISP_AW+1:2];
  assign sram_idx   = Ma[SRAM_AW+1:2];
  assign char_idx   = char_addr[DISP_AW:1];
  assign unused_ma  = ^Ma[1:0];

  // -------------------------------------------------------------------------
  // Display RAM: CPU read/write port and character read port
  // -------------------------------------------------------------------------
  logic [31:0] disp_mem [2**DISP_AW];
  logic [31:0] disp_q;

  // NOTE: memory arrays and their read registers get no reset; a reset term
  // on the array would prevent block-RAM inference. MDout is forced to zero
  // after reset through the source select, not through disp_q.
  always_ff @(posedge clk) begin
    if (!reset && dmen && is_disp) begin
      if (dmwr) begin
        disp_mem[disp_idx] <= MD2;
      end else begin
        disp_q <= disp_mem[disp_idx];
      end
    end
  end

  // Read-first: the non-blocking write above lands after this read samples,
  // so a same-cycle CPU write to the same word yields the old halfword.
  // NOTE: all sequential state uses <=; a blocking write here would make the
  // result depend on the order the simulator evaluates these blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      char_data_out <= '0;
    end else if (char_addr[0]) begin
      char_data_out <= disp_mem[char_idx][31:16];
    end else begin
      char_data_out <= disp_mem[char_idx][15:0];
    end
  end

  // -------------------------------------------------------------------------
  // Data SRAM
  // -------------------------------------------------------------------------
  logic [31:0] sram_mem [2**SRAM_AW];
  logic [31:0] sram_q;

  always_ff @(posedge clk) begin
    if (!reset && dmen && is_sram) begin
      if (dmwr) begin
        sram_mem[sram_idx] <= MD2;
      end else begin
        sram_q <= sram_mem[sram_idx];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Keyboard FIFO
  // -------------------------------------------------------------------------
  logic [7:0]     key_mem [KEY_DEPTH];
  logic [KPW-1:0] key_rd_ptr;
  logic [KPW-1:0] key_wr_ptr;
  logic [KPW:0]   key_count;
  logic           key_ovf;
  logic           key_empty;
  logic           key_full;
  logic           key_pop;
  logic           key_push;
  logic           key_drop;
  logic [31:0]    key_stat;
  logic [31:0]    key_q;

  assign key_empty = (key_count == '0);
  assign key_full  = (key_count == (KPW+1)'(KEY_DEPTH));
  // A pop on an empty FIFO is a no-op that returns zero.
  assign key_pop   = rd_en & is_keydata & ~key_empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign key_push  = key_valid & (~key_full | key_pop);
  assign key_drop  = key_valid & key_full & ~key_pop;
  assign key_stat  = {16'b0, 8'(key_count), 5'b0, key_ovf, key_full, key_empty};

  always_ff @(posedge clk) begin
    if (!reset && key_push) begin
      key_mem[key_wr_ptr] <= key_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_rd_ptr <= '0;
      key_wr_ptr <= '0;
      key_count  <= '0;
      key_ovf    <= 1'b0;
      key_q      <= '0;
    end else begin
      if (key_push) begin
        key_wr_ptr <= key_wr_ptr + KPW'(1);
      end
      if (key_pop) begin
        key_rd_ptr <= key_rd_ptr + KPW'(1);
      end
      case ({key_push, key_pop})
        2'b10:   key_count <= key_count + (KPW+1)'(1);
        2'b01:   key_count <= key_count - (KPW+1)'(1);
        default: key_count <= key_count;
      endcase

      // A drop in the same cycle as a status read re-arms the flag, so the
      // new overflow event is never lost.
      if (key_drop) begin
        key_ovf <= 1'b1;
      end else if (rd_en && is_keystat) begin
        key_ovf <= 1'b0;
      end

      if (rd_en && is_keydata) begin
        key_q <= key_pop ? {23'b0, 1'b1, key_mem[key_rd_ptr]} : '0;
      end else if (rd_en && is_keystat) begin
        key_q <= key_stat;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Response path
  // -------------------------------------------------------------------------
  src_e src_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q    <= SRC_ZERO;
      md_ready <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      md_ready <= dmen;
      bus_err  <= dmen & ~is_mapped;
      if (rd_en) begin
        if (is_disp) begin
          src_q <= SRC_DISP;
        end else if (is_sram) begin
          src_q <= SRC_SRAM;
        end else if (is_keydata || is_keystat) begin
          src_q <= SRC_KEY;
        end else begin
          src_q <= SRC_ZERO;
        end
      end
    end
  end

  // NOTE: the default assignment ahead of the case keeps this block free of
  // inferred latches even if a select value is ever left uncovered.
  always_comb begin
    MDout = '0;
    case (src_q)
      SRC_DISP: MDout = disp_q;
      SRC_SRAM: MDout = sram_q;
      SRC_KEY:  MDout = key_q;
      default:  MDout = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_fabric.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_fabric
//
// Directed bench for mem_bus_fabric with default parameters. Inputs change
// 1 ns after a rising edge, and outputs are sampled at that same point, so
// every sample sits well away from the active edge.
// ---------------------------------------------------------------------------
module tb_mem_bus_fabric;

  localparam logic [31:0] A_KEYDATA = 32'hA000_0000;
  localparam logic [31:0] A_KEYSTAT = 32'hA000_0004;

  logic        clk = 1'b0;
  logic        reset;
  logic        dmen;
  logic        dmwr;
  logic [31:0] Ma;
  logic [31:0] MD2;
  logic [31:0] MDout;
  logic        md_ready;
  logic        bus_err;
  logic [13:0] char_addr;
  logic [15:0] char_data_out;
  logic        key_valid;
  logic [7:0]  key_data;

  int compared   = 0;
  int mismatched = 0;

  mem_bus_fabric #(
    .DISP_AW  (13),
    .SRAM_AW  (12),
    .KEY_DEPTH(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dmen         (dmen),
    .dmwr         (dmwr),
    .Ma           (Ma),
    .MD2          (MD2),
    .MDout        (MDout),
    .md_ready     (md_ready),
    .bus_err      (bus_err),
    .char_addr    (char_addr),
    .char_data_out(char_data_out),
    .key_valid    (key_valid),
    .key_data     (key_data)
  );

  always #5 clk = ~clk;

  // One CPU access lasting one clock; returns 1 ns after the sampling edge.
  task automatic cpu_op(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    dmen = 1'b1;
    dmwr = wr;
    Ma   = addr;
    MD2  = data;
    @(posedge clk);
    #1;
    dmen = 1'b0;
    dmwr = 1'b0;
  endtask

  task automatic push_key(input logic [7:0] code);
    key_valid = 1'b1;
    key_data  = code;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Access and push during reset must leave no trace.
    reset = 1'b1; dmen = 1'b1; dmwr = 1'b0; Ma = A_KEYSTAT; MD2 = '0;
    char_addr = '0; key_valid = 1'b1; key_data = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; dmen = 1'b0; key_valid = 1'b0;
    compared++; if (MDout !== 32'h0) begin mismatched++; $display("FAIL reset_mdout: got %h want %h", MDout, 32'h0); end
    compared++; if (md_ready !== 1'b0) begin mismatched++; $display("FAIL reset_md_ready: got %b want 0", md_ready); end
    compared++; if (bus_err !== 1'b0) begin mismatched++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    compared++; if (char_data_out !== 16'h0) begin mismatched++; $display("FAIL reset_char: got %h want 0000", char_data_out); end
    idle_cycle();
    compared++; if (md_ready !== 1'b0) begin mismatched++; $display("FAIL reset_no_ready: got %b want 0", md_ready); end
    cpu_op(1'b0, A_KEYSTAT, '0);
    compared++; if (MDout !== 32'h0000_0001) begin mismatched++; $display("FAIL keystat_empty: got %h want %h", MDout, 32'h1); end
    compared++; if (md_ready !== 1'b1) begin mismatched++; $display("FAIL keystat_ready: got %b want 1", md_ready); end
    compared++; if (bus_err !== 1'b0) begin mismatched++; $display("FAIL keystat_bus_err: got %b want 0", bus_err); end
    idle_cycle();
    compared++; if (md_ready !== 1'b0) begin mismatched++; $display("FAIL ready_one_cycle: got %b want 0", md_ready); end
    compared++; if (MDout !== 32'h0000_0001) begin mismatched++; $display("FAIL mdout_hold: got %h want %h", MDout, 32'h1); end
  endtask

  task automatic test_mem_rw();
    cpu_op(1'b1, 32'h1000_0010, 32'hDEAD_BEEF);
    compared++; if (md_ready !== 1'b1) begin mismatched++; $display("FAIL sram_wr_ready: got %b want 1", md_ready); end
    cpu_op(1'b0, 32'h1000_0010, '0);
    compared++; if (MDout !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL sram_rd: got %h want %h", MDout, 32'hDEAD_BEEF); end
    cpu_op(1'b1, 32'hB000_0004, 32'h0BAD_F00D);
    cpu_op(1'b0, 32'hB000_0004, '0);
    compared++; if (MDout !== 32'h0BAD_F00D) begin mismatched++; $display("FAIL disp_rd: got %h want %h", MDout, 32'h0BAD_F00D); end
  endtask

  task automatic test_char_port();
    char_addr = 14'd0;
    cpu_op(1'b1, 32'hB000_0000, 32'h1234_5678);
    idle_cycle();
    compared++; if (char_data_out !== 16'h5678) begin mismatched++; $display("FAIL char_lo: got %h want 5678", char_data_out); end
    char_addr = 14'd1;
    idle_cycle();
    compared++; if (char_data_out !== 16'h1234) begin mismatched++; $display("FAIL char_hi: got %h want 1234", char_data_out); end
    // Same-cycle CPU write and char read of word 0: old data comes back.
    char_addr = 14'd0;
    cpu_op(1'b1, 32'hB000_0000, 32'hAAAA_BBBB);
    compared++; if (char_data_out !== 16'h5678) begin mismatched++; $display("FAIL char_read_first: got %h want 5678", char_data_out); end
    idle_cycle();
    compared++; if (char_data_out !== 16'hBBBB) begin mismatched++; $display("FAIL char_after_wr: got %h want bbbb", char_data_out); end
    char_addr = 14'd3;
    idle_cycle();
    compared++; if (char_data_out !== 16'h0BAD) begin mismatched++; $display("FAIL char_word1_hi: got %h want 0bad", char_data_out); end
  endtask

  task automatic test_key_overflow();
    for (int i = 0; i < 9; i++) push_key(8'h10 + 8'(i));
    cpu_op(1'b0, A_KEYSTAT, '0);
    compared++; if (MDout !== 32'h0000_0806) begin mismatched++; $display("FAIL stat_overflow: got %h want %h", MDout, 32'h806); end
    cpu_op(1'b0, A_KEYSTAT, '0);
    compared++; if (MDout !== 32'h0000_0802) begin mismatched++; $display("FAIL stat_ovf_cleared: got %h want %h", MDout, 32'h802); end
    for (int i = 0; i < 8; i++) begin
      cpu_op(1'b0, A_KEYDATA, '0);
      compared++; if (MDout !== 32'h110 + 32'(i)) begin mismatched++; $display("FAIL keydata_pop%0d: got %h want %h", i, MDout, 32'h110 + 32'(i)); end
      compared++; if (md_ready !== 1'b1) begin mismatched++; $display("FAIL keydata_ready%0d: got %b want 1", i, md_ready); end
    end
    cpu_op(1'b0, A_KEYDATA, '0);
    compared++; if (MDout !== 32'h0) begin mismatched++; $display("FAIL keydata_empty: got %h want 0", MDout); end
    cpu_op(1'b0, A_KEYSTAT, '0);
    compared++; if (MDout !== 32'h0000_0001) begin mismatched++; $display("FAIL stat_drained: got %h want %h", MDout, 32'h1); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) push_key(8'h20 + 8'(i));
    cpu_op(1'b0, A_KEYSTAT, '0);
    compared++; if (MDout !== 32'h0000_0802) begin mismatched++; $display("FAIL stat_full: got %h want %h", MDout, 32'h802); end
    key_valid = 1'b1; key_data = 8'h28;
    cpu_op(1'b0, A_KEYDATA, '0);
    key_valid = 1'b0;
    compared++; if (MDout !== 32'h120) begin mismatched++; $display("FAIL full_pushpop_head: got %h want %h", MDout, 32'h120); end
    cpu_op(1'b0, A_KEYSTAT, '0);
    compared++; if (MDout !== 32'h0000_0802) begin mismatched++; $display("FAIL full_pushpop_stat: got %h want %h", MDout, 32'h802); end
    for (int i = 0; i < 8; i++) begin
      cpu_op(1'b0, A_KEYDATA, '0);
      compared++; if (MDout !== 32'h121 + 32'(i)) begin mismatched++; $display("FAIL full_drain%0d: got %h want %h", i, MDout, 32'h121 + 32'(i)); end
    end
    // Empty FIFO: simultaneous pop returns 0 while the push lands.
    key_valid = 1'b1; key_data = 8'h33;
    cpu_op(1'b0, A_KEYDATA, '0);
    key_valid = 1'b0;
    compared++; if (MDout !== 32'h0) begin mismatched++; $display("FAIL empty_pushpop: got %h want 0", MDout); end
    cpu_op(1'b0, A_KEYSTAT, '0);
    compared++; if (MDout !== 32'h0000_0100) begin mismatched++; $display("FAIL empty_pushpop_stat: got %h want %h", MDout, 32'h100); end
    cpu_op(1'b0, A_KEYDATA, '0);
    compared++; if (MDout !== 32'h133) begin mismatched++; $display("FAIL empty_pushpop_data: got %h want %h", MDout, 32'h133); end
  endtask

  task automatic test_unmapped();
    cpu_op(1'b0, 32'h2000_0000, '0);
    compared++; if (MDout !== 32'h0) begin mismatched++; $display("FAIL unmapped_rd: got %h want 0", MDout); end
    compared++; if (bus_err !== 1'b1) begin mismatched++; $display("FAIL unmapped_err: got %b want 1", bus_err); end
    compared++; if (md_ready !== 1'b1) begin mismatched++; $display("FAIL unmapped_ready: got %b want 1", md_ready); end
    idle_cycle();
    compared++; if (bus_err !== 1'b0) begin mismatched++; $display("FAIL err_one_cycle: got %b want 0", bus_err); end
    // Near-miss of the SRAM window must not alias onto SRAM word 4.
    cpu_op(1'b1, 32'h1001_0010, 32'h0000_0055);
    compared++; if (bus_err !== 1'b1) begin mismatched++; $display("FAIL unmapped_wr_err: got %b want 1", bus_err); end
    cpu_op(1'b0, 32'h1000_0010, '0);
    compared++; if (MDout !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL unmapped_wr_discard: got %h want %h", MDout, 32'hDEAD_BEEF); end
    push_key(8'h44);
    cpu_op(1'b1, A_KEYDATA, 32'hFFFF_FFFF);
    compared++; if (bus_err !== 1'b0) begin mismatched++; $display("FAIL keydata_wr_err: got %b want 0", bus_err); end
    compared++; if (md_ready !== 1'b1) begin mismatched++; $display("FAIL keydata_wr_ready: got %b want 1", md_ready); end
    cpu_op(1'b0, A_KEYSTAT, '0);
    compared++; if (MDout !== 32'h0000_0100) begin mismatched++; $display("FAIL keydata_wr_stat: got %h want %h", MDout, 32'h100); end
    cpu_op(1'b0, A_KEYDATA, '0);
    compared++; if (MDout !== 32'h144) begin mismatched++; $display("FAIL keydata_wr_data: got %h want %h", MDout, 32'h144); end
  endtask

  task automatic test_back_to_back();
    cpu_op(1'b0, 32'h1000_0010, '0);
    compared++; if (MDout !== 32'hDEAD_BEEF || md_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_0: got %h/%b want %h/1", MDout, md_ready, 32'hDEAD_BEEF); end
    cpu_op(1'b0, 32'hB000_0004, '0);
    compared++; if (MDout !== 32'h0BAD_F00D || md_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_1: got %h/%b want %h/1", MDout, md_ready, 32'h0BAD_F00D); end
    cpu_op(1'b0, A_KEYSTAT, '0);
    compared++; if (MDout !== 32'h0000_0001 || md_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_2: got %h/%b want %h/1", MDout, md_ready, 32'h1); end
    idle_cycle();
    compared++; if (md_ready !== 1'b0) begin mismatched++; $display("FAIL b2b_idle: got %b want 0", md_ready); end
  endtask

  initial begin
    test_reset();
    test_mem_rw();
    test_char_port();
    test_key_overflow();
    test_full_push_pop();
    test_unmapped();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_bus_fabric.md
# mem_bus_fabric

Parametrised data-memory fabric between the processor's memory stage and its data-side targets: display RAM, keyboard FIFO with status, and data SRAM. It replaces the fixed single-register data-memory decoder. It adds a registered read path with a ready pulse, a keyboard FIFO with overflow tracking, an independent character-fetch port for the VGA tile engine, and an unmapped-access error flag. The processor memory stage connects on one side; the display controller and keyboard receiver connect on the other.

## Interface
- DISP_AW, 13: display RAM word-address width (2^13 × 32-bit words).
- SRAM_AW, 12: data SRAM word-address width.
- KEY_DEPTH, 8: keyboard FIFO entries, power of two, at least 2.
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- dmen  in  1  memory access request this cycle.
- dmwr  in  1  1 = write, 0 = read; qualified by dmen.
- Ma  in  32  byte address; bits [1:0] ignored.
- MD2  in  32  write data.
- MDout  out  32  registered read data.
- md_ready  out  1  one-cycle pulse: access issued last cycle has completed.
- bus_err  out  1  one-cycle pulse: access issued last cycle hit an unmapped address.
- char_addr  in  DISP_AW+1  halfword address for the tile engine.
- char_data_out  out  16  registered halfword for the tile engine.
- key_valid  in  1  push strobe from the keyboard receiver.
- key_data  in  8  scan code, sampled when key_valid = 1.

## Operation
- Address decode, word address = Ma[31:2]:
  - Ma[31:20] = 12'hB00: display RAM, word index Ma[DISP_AW+1:2].
  - Ma = 32'hA000_0000: KEYDATA, read-only.
  - Ma = 32'hA000_0004: KEYSTAT, read-only.
  - Ma[31:16] = 16'h1000: SRAM, word index Ma[SRAM_AW+1:2].
  - Any other address is unmapped.
- Display and SRAM writes: MD2 is written at the clk edge where dmen & dmwr = 1.
- Display and SRAM reads: the word is presented on MDout one cycle later.
- KEYDATA read:
  - FIFO not empty: pops the head and returns {23'b0, 1'b1, code[7:0]}.
  - FIFO empty: returns 32'h0 and pops nothing.
- KEYSTAT read returns {16'b0, count[7:0], 5'b0, overflow, full, empty}. The read clears overflow, and the returned value reflects overflow before the clear.
- Writes to KEYDATA or KEYSTAT are ignored: no state change, md_ready pulses, bus_err stays 0.
- Unmapped access:
  - Writes are discarded.
  - Reads return 32'h0.
  - bus_err and md_ready both pulse.
- Keyboard FIFO push on key_valid:
  - Full and no pop in the same cycle: the code is dropped and overflow is set (sticky).
  - Full with a simultaneous KEYDATA pop: both the pop and the push succeed, and count is unchanged.
  - Empty with a simultaneous pop: the pop returns 0 and the push lands.
- Pointers wrap modulo KEY_DEPTH. count ranges 0..KEY_DEPTH.
- Character port: char_data_out = word[char_addr[DISP_AW:1]] half, where char_addr[0] = 0 selects bits [15:0] and 1 selects [31:16]. The port runs every cycle, independent of dmen.
- Display RAM is true dual-port and read-first. A CPU write and a char read to the same word in one cycle return the old data on char_data_out. A CPU read of a word being written in the same cycle also returns old data.
- dmen = 0: no access. MDout holds its last value, and md_ready and bus_err are 0.

## Timing
- Reset values:
  - MDout = 0, char_data_out = 0, md_ready = 0, bus_err = 0.
  - FIFO empty, count = 0, overflow = 0.
  - RAM contents are not cleared.
- Reset takes precedence over everything. An access or push in the reset cycle has no effect, and no md_ready pulse follows it.
- Latency:
  - Access issued at edge N: MDout, md_ready and bus_err are valid after edge N+1.
  - Char port: char_addr at edge N gives char_data_out after edge N+1.
- Fully pipelined: a new access is accepted every cycle, and back-to-back reads produce consecutive md_ready pulses.
- FIFO state changes take effect at the edge. A KEYSTAT read in cycle N+1 sees a push or pop from cycle N.

## Test plan
- Reset, then read KEYSTAT → MDout = 32'h0000_0001 (empty), md_ready pulses one cycle after the request.
- Write 32'hDEAD_BEEF to 0x1000_0010, then read it back on the next cycle → MDout = 32'hDEAD_BEEF one cycle after the read. The same holds for 0xB000_0004.
- Write 32'h1234_5678 to 0xB000_0000, then set char_addr = 0 and then 1 → char_data_out = 16'h5678, then 16'h1234. A same-cycle write plus char read of word 0 returns the old data.
- Push 9 codes (8'h10..8'h18) with KEY_DEPTH = 8. KEYSTAT → 32'h0000_0806 (count 8, overflow, full); the next KEYSTAT → 32'h0000_0802. Eight KEYDATA reads → 32'h110..32'h117; a ninth → 32'h0.
- With the FIFO full, push and pop in the same cycle → pop returns the head, count stays 8, overflow stays 0.
- Read 0x2000_0000 → MDout = 0, bus_err and md_ready pulse together. Write to 0xA000_0000 → bus_err = 0 and the FIFO is unchanged.
